// File: rtl/product_accumulator_if.sv
// Handshake bundle between the product source, the accumulator and the sum consumer.
// master drives starts/products and consumes sums; slave is the accumulator itself.
interface product_accumulator_if #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 64
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] prod;
    logic             prod_ovf;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc;
    logic             acc_sat;
    logic             acc_err;
    logic             busy;

    modport master (
        output start, len, prod_valid, prod, prod_ovf, acc_ready,
        input  prod_ready, acc_valid, acc, acc_sat, acc_err, busy
    );

    modport slave (
        input  start, len, prod_valid, prod, prod_ovf, acc_ready,
        output prod_ready, acc_valid, acc, acc_sat, acc_err, busy
    );
endinterface

// File: rtl/product_accumulator.sv
// Accumulates a counted burst of signed 64-bit products with saturation, then
// holds the sum and sticky flags until the downstream handshake completes.
module product_accumulator #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned ACC_W = 64
) (
    input logic                   clk,
    input logic                   rst,
    product_accumulator_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic [ACC_W:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        err_d   = err_q;
        sum     = {acc_q[ACC_W-1], acc_q} + {bus.prod[ACC_W-1], bus.prod};

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                    err_d = 1'b0;
                    if (bus.len != '0) begin
                        cnt_d   = bus.len;
                        state_d = StAccum;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAccum: begin
                if (bus.prod_valid) begin
                    // Top two bits of the sign-extended sum disagree only on overflow.
                    unique case (sum[ACC_W:ACC_W-1])
                        2'b01: begin
                            acc_d = AccMax;
                            sat_d = 1'b1;
                        end
                        2'b10: begin
                            acc_d = AccMin;
                            sat_d = 1'b1;
                        end
                        default: acc_d = sum[ACC_W-1:0];
                    endcase
                    err_d = err_q | bus.prod_ovf;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.acc_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.prod_ready = (state_q == StAccum);
    assign bus.acc_valid  = (state_q == StDone);
    assign bus.busy       = (state_q != StIdle);
    assign bus.acc        = acc_q;
    assign bus.acc_sat    = sat_q;
    assign bus.acc_err    = err_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: directed vector table, reset corner case, then random bursts
// checked against a saturating-sum reference model.
module tb_product_accumulator;
    localparam int unsigned LEN_W = 8;
    localparam longint      MAXV  = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam longint      MINV  = 64'sh8000_0000_0000_0000;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    product_accumulator_if #(.LEN_W(LEN_W), .ACC_W(64)) bus ();

    product_accumulator #(.LEN_W(LEN_W), .ACC_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int              len;
        logic [3:0][63:0] p;
        logic [3:0]      o;
        int              gap;
        int              hold;
        logic [63:0]     e_acc;
        logic            e_sat;
        logic            e_err;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] tx_prod[$];
    logic        tx_ovf[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int l, input longint a, input longint b, input longint c,
                                input longint d, input logic [3:0] o, input int gap,
                                input int hold, input longint ea, input logic es,
                                input logic ee);
        vec_t v;
        v.len = l;
        v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
        v.o = o; v.gap = gap; v.hold = hold;
        v.e_acc = ea; v.e_sat = es; v.e_err = ee;
        return v;
    endfunction

    // Reference: saturating signed sum over the queued products.
    task automatic model(output logic [63:0] e_acc, output logic e_sat, output logic e_err);
        longint a = 0;
        e_sat = 1'b0;
        e_err = 1'b0;
        foreach (tx_prod[i]) begin
            longint p = tx_prod[i];
            if (p > 0 && a > MAXV - p) begin
                a = MAXV; e_sat = 1'b1;
            end else if (p < 0 && a < MINV - p) begin
                a = MINV; e_sat = 1'b1;
            end else begin
                a = a + p;
            end
            e_err = e_err | tx_ovf[i];
        end
        e_acc = a;
    endtask

    // One full accumulation from IDLE back to IDLE. gap: 0 none, 1 alternate, 2 random.
    task automatic run_txn(input int len_v, input int gap, input int hold,
                           input logic [63:0] e_acc, input logic e_sat, input logic e_err);
        int idx = 0;
        int cyc = 0;
        int budget = len_v * 4 + 20;
        bus.start = 1'b1;
        bus.len = LEN_W'(len_v);
        step();
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        if (len_v != 0) begin
            chk("cleared_acc", bus.acc, 0);
            chk("accum_valid_low", bus.acc_valid, 0);
        end
        while (idx < len_v && cyc < budget) begin
            logic v;
            v = (gap == 0) ? 1'b1 : (gap == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 9) < 7);
            bus.prod_valid = v;
            bus.prod = v ? tx_prod[idx] : {$urandom, $urandom};
            bus.prod_ovf = v ? tx_ovf[idx] : 1'b1;
            bus.start = $urandom_range(0, 1);
            bus.len = 8'd0;
            chk("prod_ready", bus.prod_ready, 1);
            step();
            if (v) idx++;
            cyc++;
            chk("valid_timing", bus.acc_valid, (idx == len_v));
        end
        bus.prod_valid = 1'b0;
        bus.start = 1'b0;
        if (idx < len_v) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", idx, len_v);
        end
        for (int h = 0; h <= hold; h++) begin
            chk("done_valid", bus.acc_valid, 1);
            chk("done_ready_low", bus.prod_ready, 0);
            chk("acc", bus.acc, e_acc);
            chk("acc_sat", bus.acc_sat, e_sat);
            chk("acc_err", bus.acc_err, e_err);
            if (h < hold) begin
                bus.prod_valid = 1'b1;
                bus.prod = 64'h0123_4567_89AB_CDEF;
                bus.prod_ovf = 1'b1;
                bus.start = 1'b1;
                step();
            end
        end
        bus.prod_valid = 1'b0;
        bus.acc_ready = 1'b1;
        bus.start = 1'b1;
        bus.len = 8'd3;
        step();
        bus.acc_ready = 1'b0;
        bus.start = 1'b0;
        chk("idle_valid_low", bus.acc_valid, 0);
        chk("idle_busy_low", bus.busy, 0);
        chk("idle_holds_acc", bus.acc, e_acc);
    endtask

    initial begin
        logic [63:0] e_acc;
        logic        e_sat, e_err;
        bus.start = 1'b0; bus.len = '0; bus.prod_valid = 1'b0; bus.prod = '0;
        bus.prod_ovf = 1'b0; bus.acc_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_acc", bus.acc, 0);
        chk("rst_valid", bus.acc_valid, 0);
        chk("rst_ready", bus.prod_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_flags", {bus.acc_sat, bus.acc_err}, 0);
        step();
        step();
        rst = 1'b0;

        vecs[0] = mk(3, 5, -2, 10, 0, 4'b0000, 0, 0, 13, 0, 0);
        vecs[1] = mk(2, 64'sh7FFF_FFFF_FFFF_FFF0, 32, 0, 0, 4'b0000, 0, 0, MAXV, 1, 0);
        vecs[2] = mk(2, 64'sh8000_0000_0000_0001, -5, 0, 0, 4'b0000, 0, 0, MINV, 1, 0);
        vecs[3] = mk(3, 64'sh7FFF_FFFF_FFFF_FFF0, 32, -1, 0, 4'b0000, 0, 1,
                     64'sh7FFF_FFFF_FFFF_FFFE, 1, 0);
        vecs[4] = mk(4, 1, 2, 3, 4, 4'b0000, 1, 5, 10, 0, 0);
        vecs[5] = mk(0, 0, 0, 0, 0, 4'b0000, 0, 2, 0, 0, 0);
        vecs[6] = mk(2, 100, -50, 0, 0, 4'b0001, 0, 0, 50, 0, 1);
        vecs[7] = mk(4, MINV, -1, 1, MAXV, 4'b0000, 0, 0, 0, 1, 0);

        for (int i = 0; i < 8; i++) begin
            tx_prod.delete();
            tx_ovf.delete();
            for (int k = 0; k < vecs[i].len; k++) begin
                tx_prod.push_back(vecs[i].p[k]);
                tx_ovf.push_back(vecs[i].o[k]);
            end
            run_txn(vecs[i].len, vecs[i].gap, vecs[i].hold,
                    vecs[i].e_acc, vecs[i].e_sat, vecs[i].e_err);
        end

        // Reset after two of four beats: everything clears at once, no result pulse.
        bus.start = 1'b1; bus.len = 8'd4;
        step();
        bus.start = 1'b0;
        bus.prod_valid = 1'b1; bus.prod = 64'd1000; bus.prod_ovf = 1'b1;
        step();
        step();
        bus.prod_valid = 1'b0; bus.prod_ovf = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_acc", bus.acc, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready", bus.prod_ready, 0);
        chk("midrst_err", bus.acc_err, 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("midrst_no_valid", bus.acc_valid, 0);
        end
        tx_prod.delete(); tx_ovf.delete();
        tx_prod.push_back(-64'sd7); tx_ovf.push_back(1'b0);
        run_txn(1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0);

        // Random bursts; the last one uses the maximum length.
        for (int t = 0; t < 21; t++) begin
            int l = (t == 20) ? 255 : $urandom_range(0, 12);
            tx_prod.delete();
            tx_ovf.delete();
            for (int k = 0; k < l; k++) begin
                logic [63:0] p;
                case ($urandom_range(0, 2))
                    0: p = 64'($signed($urandom_range(0, 200)) - 100);
                    1: p = {$urandom, $urandom};
                    default: p = $urandom_range(0, 1) ? 64'h7FFF_FFFF_FFFF_FF00
                                                      : 64'h8000_0000_0000_0100;
                endcase
                tx_prod.push_back(p);
                tx_ovf.push_back($urandom_range(0, 7) == 0);
            end
            model(e_acc, e_sat, e_err);
            run_txn(l, (t == 20) ? 0 : 2, $urandom_range(0, 3), e_acc, e_sat, e_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter LEN_W, default 8: width of the beat-count input `len`.
REQ-002 Parameter ACC_W, fixed at 64: product and accumulator width, matching the upstream multiplier's 64-bit signed product.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of products to accumulate; sampled with start.
REQ-007 prod_valid  input  1  upstream product available.
REQ-008 prod_ready  output  1  block accepts a product this cycle.
REQ-009 prod  input  64  signed two's-complement product.
REQ-010 prod_ovf  input  1  upstream multiplier overflow flag; qualified by prod_valid.
REQ-011 acc_valid  output  1  final sum available.
REQ-012 acc_ready  input  1  downstream consumes the sum.
REQ-013 acc  output  64  signed accumulated sum.
REQ-014 acc_sat  output  1  sticky: saturation occurred in this accumulation.
REQ-015 acc_err  output  1  sticky: any accepted product had prod_ovf=1 in this accumulation.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ACCUM, DONE, encoded in registers; all outputs are derived from registers or the state, with no combinational input-to-output path except through the state.
REQ-018 IDLE, start=1, len!=0: next state ACCUM; acc<=0, acc_sat<=0, acc_err<=0, cnt<=len.
REQ-019 IDLE, start=1, len=0: next state DONE; acc<=0, acc_sat<=0, acc_err<=0.
REQ-020 IDLE, start=0: hold; acc, acc_sat and acc_err retain the previous result.
REQ-021 prod_ready=1 only in ACCUM; a beat is accepted when prod_valid && prod_ready.
REQ-022 Accepted beat: form the 65-bit sign-extended sum acc+prod.
  - On positive overflow: acc<=0x7FFF_FFFF_FFFF_FFFF and acc_sat<=1.
  - On negative overflow: acc<=0x8000_0000_0000_0000 and acc_sat<=1.
  - Otherwise: acc<=sum[63:0].
REQ-023 Accepted beat: acc_err<=acc_err|prod_ovf; cnt<=cnt-1.
REQ-024 Accepted beat with cnt==1: next state DONE; the sum is visible on acc in the same cycle acc_valid rises (one-cycle latency from the last beat).
REQ-025 ACCUM with no accepted beat: all state holds; no timeout.
REQ-026 DONE: acc_valid=1.
  - acc, acc_sat and acc_err are stable while acc_valid=1 && acc_ready=0.
  - On acc_ready=1: next state IDLE and acc_valid drops next cycle.
REQ-027 start is ignored in ACCUM and DONE.
  - start=1 coincident with the DONE handshake is ignored; a new start needs IDLE.
REQ-028 Throughput: one product per cycle while prod_valid stays high.
  - An accumulation of N beats takes N cycles in ACCUM plus at least 1 cycle in DONE.
REQ-029 Saturation is sticky per accumulation; later beats add to the clamped value using the same rule.
REQ-030 len=2^LEN_W-1 (255 at default) accepts exactly 255 beats; cnt never wraps.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, acc=0, cnt=0, acc_sat=0, acc_err=0.
  - Consequently acc_valid=0, prod_ready=0, busy=0.
REQ-032 rst asserted mid-ACCUM or mid-DONE aborts the accumulation: no acc_valid pulse, and partial sums are discarded.
REQ-033 After rst deasserts, the first start is honoured on the first rising edge.

Verification
REQ-034 Basic sum: start, len=3; prods 5, -2, 10 on consecutive cycles -> acc=13, acc_sat=0, acc_err=0; acc_valid rises the cycle after the third beat.
REQ-035 Saturation: len=2; prods 0x7FFF_FFFF_FFFF_FFF0 and 0x20 -> acc=0x7FFF_FFFF_FFFF_FFFF, acc_sat=1. A repeat run with 0x8000_0000_0000_0001 and -5 -> acc=0x8000_0000_0000_0000, acc_sat=1.
REQ-036 Backpressure and gaps: len=4, prod_valid toggling 1,0,1,0,...; acc_ready held 0 for 5 cycles in DONE -> acc stable and acc_valid high throughout; exactly 4 beats accepted.
REQ-037 Zero length and flags: start with len=0 -> DONE next cycle with acc=0. Then len=2 with prod_ovf=1 on beat 1 only -> acc_err=1 on the result.
REQ-038 Reset mid-operation: rst pulsed after 2 of 4 beats -> outputs reset immediately and no acc_valid pulse. A following start with len=1, prod=-7 -> acc=0xFFFF_FFFF_FFFF_FFF9.
REQ-039 Protocol checks across all scenarios: start ignored while busy=1; no beat accepted outside ACCUM; acc stable while acc_valid && !acc_ready.
